// File: rtl/shmx_if.sv
// Shifter/mux request and result bundle: master issues operands
// and start; slave returns busy/done and the held result fields.
interface shmx_if #(
   parameter int W   = 36,
   parameter int SCW = 8
);
   logic           start;
   logic [1:0]     CRAM_SH;
   logic [SCW-1:0] SC;
   logic [0:W-1]   AR;
   logic [0:W-1]   ARX;
   logic           longEnable;
   logic           busy;
   logic           done;
   logic [0:W-1]   SH;
   logic [3:0]     XR;
   logic           indexed;
   logic           ARextended;
   logic           ARparityOdd;

   modport master (
      output start, CRAM_SH, SC, AR, ARX, longEnable,
      input  busy, done, SH, XR, indexed, ARextended, ARparityOdd
   );

   modport slave (
      input  start, CRAM_SH, SC, AR, ARX, longEnable,
      output busy, done, SH, XR, indexed, ARextended, ARparityOdd
   );
endinterface

// File: rtl/shmx.sv
// Multi-cycle funnel shifter / AR-ARX mux with held result fields.
// Ports: clk, resetN (async low), bus (shmx_if.slave).
module shmx #(
   parameter int W    = 36,
   parameter int SCW  = 8,
   parameter int STEP = 8
) (
   input logic   clk,
   input logic   resetN,
   shmx_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       st_q, st_d;
   logic [0:2*W-1]   f_q, f_d, f_nx;
   logic [SCW-1:0]   rem_q, rem_d, stp;
   logic [3:0]       xc_q, xc_d;
   logic             ec_q, ec_d;
   logic [0:W-1]     sh_q, sh_d;
   logic [3:0]       xr_q, xr_d;
   logic             ext_q, ext_d;
   logic [3:0]       xf;
   logic             ef;
   logic             go_shift;

   // Index and extended-address qualifiers are taken from the
   // operands at acceptance, then published only on DONE entry.
   assign xf = bus.ARX[W-22:W-19];
   assign ef = bus.longEnable & ~bus.AR[0] & (|bus.AR[6:17]);

   assign go_shift = (bus.CRAM_SH == 2'd0) &&
                     (32'(bus.SC) < 2*W);

   assign stp  = (32'(rem_q) > STEP) ? SCW'(STEP) : rem_q;
   assign f_nx = f_q << stp;

   always_comb begin
      st_d  = st_q;
      f_d   = f_q;
      rem_d = rem_q;
      xc_d  = xc_q;
      ec_d  = ec_q;
      sh_d  = sh_q;
      xr_d  = xr_q;
      ext_d = ext_q;
      case (st_q)
         IDLE: begin
            if (bus.start) begin
               xc_d = xf;
               ec_d = ef;
               if (go_shift) begin
                  f_d   = {bus.AR, bus.ARX};
                  rem_d = bus.SC;
                  st_d  = SHIFT;
               end else begin
                  st_d  = DONE;
                  xr_d  = xf;
                  ext_d = ef;
                  unique case (1'b1)
                     (bus.CRAM_SH == 2'd0): sh_d = '0;
                     (bus.CRAM_SH == 2'd1): sh_d = bus.AR;
                     (bus.CRAM_SH == 2'd2): sh_d = bus.ARX;
                     (bus.CRAM_SH == 2'd3):
                        sh_d = {bus.AR[W/2:W-1],
                                bus.AR[0:W/2-1]};
                  endcase
               end
            end
         end
         SHIFT: begin
            f_d   = f_nx;
            rem_d = rem_q - stp;
            // Final step: publish on the same edge.
            if (rem_q == stp) begin
               st_d  = DONE;
               sh_d  = f_nx[0:W-1];
               xr_d  = xc_q;
               ext_d = ec_q;
            end
         end
         DONE:    st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         st_q  <= IDLE;
         f_q   <= '0;
         rem_q <= '0;
         xc_q  <= '0;
         ec_q  <= 1'b0;
         sh_q  <= '0;
         xr_q  <= '0;
         ext_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         f_q   <= f_d;
         rem_q <= rem_d;
         xc_q  <= xc_d;
         ec_q  <= ec_d;
         sh_q  <= sh_d;
         xr_q  <= xr_d;
         ext_q <= ext_d;
      end
   end

   assign bus.busy        = (st_q != IDLE);
   assign bus.done        = (st_q == DONE);
   assign bus.SH          = sh_q;
   assign bus.XR          = xr_q;
   assign bus.indexed     = |xr_q;
   assign bus.ARextended  = ext_q;
   assign bus.ARparityOdd = ^sh_q;

endmodule

// File: doc/shmx.md
SHMX -- requirements
Module: shmx

Interface
REQ-001 Parameter W, default 36: AR/ARX/SH word width, bit 0 = MSB; SHALL be even and >= 18.
REQ-002 Parameter SCW, default 8: shift-count width.
REQ-003 Parameter STEP, default 8: maximum bits shifted per clock in funnel mode, 1..W.
REQ-004 Port clk, input, 1: sole clock, all state changes on rising edge.
REQ-005 Port resetN, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request; sampled only in IDLE.
REQ-007 Port CRAM_SH, input, 2: mode; 0 funnel shift, 1 pass AR, 2 pass ARX, 3 swap AR halves.
REQ-008 Port SC, input, SCW: shift count, unsigned, mode 0 only.
REQ-009 Ports AR, ARX, input, W each: operands [0:W-1].
REQ-010 Port longEnable, input, 1: extended-addressing qualifier.
REQ-011 Port busy, output, 1: high while the operation is in progress.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port SH, output, W [0:W-1]: result, held from done until the next done.
REQ-014 Ports XR (4), indexed (1), ARextended (1), ARparityOdd (1): outputs, held with SH.

Function
REQ-015 States IDLE, SHIFT, DONE; IDLE+start -> SHIFT (mode 0, SC < 2W) or DONE (all other cases); SHIFT -> DONE when remaining count is 0; DONE -> IDLE unconditionally.
REQ-016 On accepted start the block SHALL capture AR, ARX, SC, CRAM_SH, longEnable into internal registers; later input changes SHALL NOT affect the result.
REQ-017 start while busy or in DONE SHALL be ignored, no queuing.
REQ-018 busy SHALL be high in SHIFT and DONE, low in IDLE; done SHALL be high only in DONE.
REQ-019 Mode 0: SH = bits [0:W-1] of the 2W-bit {AR,ARX} shifted left by SC, zero fill from right.
REQ-020 Mode 0: each SHIFT cycle shifts by min(remaining, STEP) and decrements remaining by the same amount.
REQ-021 Mode 0 latency: done asserted k+1 cycles after the start edge, k = max(1, ceil(SC/STEP)); SC = 0 takes one SHIFT cycle, shift 0.
REQ-022 Mode 0 with SC >= 2W: SH = 0 and direct IDLE -> DONE transition, latency 1.
REQ-023 Modes 1, 2, 3: direct IDLE -> DONE transition, latency 1; SH = AR, ARX, {AR[W/2:W-1], AR[0:W/2-1]} respectively.
REQ-024 XR = captured ARX bits [W-22:W-19] (bits 14..17 for W=36); indexed = (XR != 0).
REQ-025 ARextended = captured longEnable AND captured AR bit 0 = 0 AND captured AR bits [6:17] nonzero.
REQ-026 ARparityOdd = XOR-reduction of the final SH.
REQ-027 SH, XR, indexed, ARextended, and ARparityOdd SHALL update only on entry to DONE; outputs SHALL NOT show intermediate SHIFT values.

Reset
REQ-028 resetN low SHALL asynchronously force IDLE, busy=0, done=0, SH=0, XR=0, indexed=0, ARextended=0, ARparityOdd=0, remaining count=0.
REQ-029 Reset mid-SHIFT SHALL abort without a done pulse; the first start after resetN rises SHALL behave as from power-up.
REQ-030 Release of resetN SHALL take effect at the next clk rising edge with resetN high; no start is accepted in the release cycle's preceding edge.

Verification
REQ-031 W=36, STEP=8, mode 0, AR=0o000000000001, ARX=0o400000000000, SC=1 -> done 2 cycles after start, SH=0o000000000003, ARparityOdd=0.
REQ-032 Mode 0, SC=36, ARX=0o123456765432 -> 5 SHIFT cycles, done at cycle 6, SH=0o123456765432, XR=0o17 & field, indexed per field.
REQ-033 Mode 0, SC=80 -> done at cycle 1, SH=0; mode 3, AR=0o123456654321 -> done at cycle 1, SH=0o654321123456.
REQ-034 start re-pulsed with different operands during SHIFT -> ignored, SH from the first operands only, exactly one done.
REQ-035 resetN low during the 3rd SHIFT cycle of SC=36 -> immediate busy=0, SH=0, no done; next start with SC=4 -> done at cycle 2, correct SH.
REQ-036 Mode 0 sweep, SC 0..80 with random operands, STEP in {1,8,36} -> SH matches reference funnel model, latency per REQ-021/022.
